// File: rtl/fifo_read_drainer.sv
// ----------------------------------------------------------------------------
// fifo_read_drainer
//   Read-side consumer for an asynchronous FIFO, living in the read clock
//   domain. It issues rden strobes whenever the FIFO is not empty and there
//   is room for the word in a 2-entry skid buffer. It captures the
//   1-cycle-latency rddata and presents the words downstream as a
//   valid/ready stream that runs bubble-free at full throughput.
//
// Optional feature macro: DRAIN_COUNT_EN
//   When defined, adds the xfer_cnt output. It is a wrapping count of
//   accepted words.
//
// Ports
//   rdclk    in   1      read-domain clock, rising edge
//   rdrst    in   1      asynchronous active-low reset
//   empty    in   1      FIFO empty flag, synchronous to rdclk
//   rden     out  1      FIFO read strobe (combinational)
//   rddata   in   W      FIFO read data, valid the cycle after rden
//   m_valid  out  1      output word valid
//   m_data   out  W      output word (head of the skid buffer)
//   m_ready  in   1      downstream accept
//   xfer_cnt out  CNT_W  accepted-word counter (DRAIN_COUNT_EN only)
// ----------------------------------------------------------------------------
module fifo_read_drainer #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             rdclk,
    input  logic             rdrst,
    input  logic             empty,
    output logic             rden,
    input  logic [W-1:0]     rddata,
    output logic             m_valid,
    output logic [W-1:0]     m_data,
    input  logic             m_ready
`ifdef DRAIN_COUNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    // The state encoding equals the number of words held in the skid buffer.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } occ_e;

    occ_e         state_q, state_d;
    logic         inflight_q;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;

    logic         accept;
    logic         capture;
    logic [1:0]   occ;
    logic [2:0]   credit;

    assign m_valid = (state_q != S0);
    assign m_data  = head_q;
    assign accept  = m_valid & m_ready;
    assign capture = inflight_q;
    assign occ     = state_q;

    // Slots committed after this edge: held + arriving - leaving.
    // accept implies occ >= 1, so the subtraction cannot underflow.
    assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, accept};
    assign rden   = rdrst & ~empty & (credit < 3'd2);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S0: begin
                if (capture) begin
                    head_d  = rddata;
                    state_d = S1;
                end
            end
            S1: begin
                case ({capture, accept})
                    2'b10: begin
                        tail_d  = rddata;
                        state_d = S2;
                    end
                    2'b01: state_d = S0;
                    // The head leaves and the arriving word takes its place.
                    2'b11: head_d = rddata;
                    default: ;
                endcase
            end
            S2: begin
                if (accept) begin
                    head_d  = tail_q;
                    state_d = S1;
                end
            end
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge rdclk or negedge rdrst) begin
        if (!rdrst) begin
            state_q    <= S0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rden;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // The credit rule must never let a word arrive while both slots are full.
    a_no_capture_in_s2 : assert property (
        @(posedge rdclk) disable iff (!rdrst) !(capture && state_q == S2)
    );

`ifdef DRAIN_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d    = cnt_q + CNT_W'(accept);
    assign xfer_cnt = cnt_q;

    always_ff @(posedge rdclk or negedge rdrst) begin
        if (!rdrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // CNT_W only sizes the counter; keep an elaboration sanity check on it.
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_fifo_read_drainer.sv
// ----------------------------------------------------------------------------
// tb_fifo_read_drainer
//   Directed bench for fifo_read_drainer. A small FIFO model holds the
//   words. It answers each rden with rddata one cycle later. A scoreboard
//   queue holds every word pushed, in order, and each accepted m_data is
//   checked against its head. Inputs change just after the falling edge.
//   Outputs are sampled in the low phase.
// ----------------------------------------------------------------------------
module tb_fifo_read_drainer;

    logic       rdclk = 1'b0;
    logic       rdrst;
    logic       empty;
    logic       rden;
    logic [7:0] rddata;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
`ifdef DRAIN_COUNT_EN
    logic [3:0] xfer_cnt;
`endif

    int         checks;
    int         errors;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic       force_empty;
    int         outst;
    int         acc_total;
    int         base;

    always #5 rdclk = ~rdclk;

    fifo_read_drainer #(
        .W     (8),
        .CNT_W (4)
    ) dut (
        .rdclk   (rdclk),
        .rdrst   (rdrst),
        .empty   (empty),
        .rden    (rden),
        .rddata  (rddata),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready)
`ifdef DRAIN_COUNT_EN
        ,
        .xfer_cnt(xfer_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    // Recompute empty from the FIFO model and let combinational outputs settle.
    task automatic settle();
        empty = force_empty || (fq.size() == 0);
        #1;
        chk("no_rden_when_empty", rden & empty, 0);
    endtask

    // Score the coming edge, cross it, then let the FIFO model answer a read.
    task automatic advance();
        logic rd_now;
        logic acc_now;
        rd_now  = rden;
        acc_now = m_valid & m_ready;
        if (acc_now) begin
            chk("accept_has_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                chk("order", m_data, exp_q.pop_front());
                acc_total++;
            end
        end
        outst = outst + int'(rd_now) - int'(acc_now);
        chk("outstanding_le2", outst <= 2, 1);
        @(posedge rdclk);
        @(negedge rdclk);
        if (rd_now) begin
            chk("fifo_underflow", fq.size() != 0, 1);
            if (fq.size() != 0) rddata = fq.pop_front();
        end
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            if (exp_q.size() == 0 && !m_valid) break;
            advance();
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        outst       = 0;
        acc_total   = 0;
        rdrst       = 1'b0;
        m_ready     = 1'b0;
        force_empty = 1'b0;
        empty       = 1'b1;
        rddata      = '0;

        // Reset values
        @(negedge rdclk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_rden", rden, 0);
`ifdef DRAIN_COUNT_EN
        chk("rst_xfer_cnt", xfer_cnt, 0);
`endif
        rdrst = 1'b1;
        settle();
        chk("idle_rden", rden, 0);
        advance();

        // T2 streaming: rden on ticks 0..7; words on ticks 2..9
        for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
        m_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            settle();
            chk("t2_rden", rden, k <= 7);
            chk("t2_valid", m_valid, (k >= 2 && k <= 9));
            if (k >= 2 && k <= 9) chk("t2_data", m_data, 8'h11 + k - 2);
            advance();
        end

        // T3 back-pressure: two reads, then hold 0xA0
        m_ready = 1'b0;
        base    = acc_total;
        for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("t3_rden", rden, k < 2);
            if (k >= 2) begin
                chk("t3_valid", m_valid, 1);
                chk("t3_hold", m_data, 8'hA0);
            end
            advance();
        end
        m_ready = 1'b1;
        drain(30);
        chk("t3_count", acc_total - base, 6);

        // T4 empty rises after 3 reads
        base = acc_total;
        push(8'h31); push(8'h32); push(8'h33);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t4_rden_on", rden, 1);
            advance();
        end
        force_empty = 1'b1;
        push(8'h34); push(8'h35); push(8'h36);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t4_rden_off", rden, 0);
            advance();
        end
        chk("t4_first3", acc_total - base, 3);
        force_empty = 1'b0;
        drain(30);
        chk("t4_all6", acc_total - base, 6);

        // T1 reset mid-stream with two words buffered
        m_ready = 1'b0;
        push(8'h51); push(8'h52); push(8'h53);
        for (int k = 0; k < 3; k++) begin
            settle();
            advance();
        end
        settle();
        chk("t1_full_valid", m_valid, 1);
        chk("t1_full_data", m_data, 8'h51);
        chk("t1_full_rden", rden, 0);
        rdrst = 1'b0;
        #1;
        chk("t1_rst_valid", m_valid, 0);
        chk("t1_rst_rden", rden, 0);
        chk("t1_rst_data", m_data, 0);
        fq.delete();
        exp_q.delete();
        outst = 0;
        advance();
        advance();
        rdrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t1_post_rden", rden, 0);
            chk("t1_post_valid", m_valid, 0);
            advance();
        end

        // T5 random ready/empty, 1000 words
        begin
            int pushed;
            pushed = 0;
            base   = acc_total;
            for (int c = 0; c < 20000 && (pushed < 1000 || exp_q.size() != 0 || m_valid); c++) begin
                if (pushed < 1000 && fq.size() < 4 && $urandom_range(0, 3) != 0) begin
                    push(8'(pushed * 7 + 3));
                    pushed++;
                end
                m_ready     = ($urandom_range(0, 3) != 0);
                force_empty = ($urandom_range(0, 4) == 0);
                settle();
                advance();
            end
            force_empty = 1'b0;
            chk("t5_pushed", pushed, 1000);
            chk("t5_accepted", acc_total - base, 1000);
            chk("t5_sb_empty", exp_q.size(), 0);
        end

`ifdef DRAIN_COUNT_EN
        // T6 counter wrap with CNT_W=4
        rdrst = 1'b0;
        #1;
        chk("t6_rst0", xfer_cnt, 0);
        fq.delete();
        exp_q.delete();
        outst = 0;
        advance();
        rdrst   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(i));
        drain(60);
        chk("t6_wrap", xfer_cnt, 1);
        rdrst = 1'b0;
        #1;
        chk("t6_rst", xfer_cnt, 0);
        advance();
        rdrst = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
